avalon_bus_master: RTL and testbench

- Initiator side of the CPU's Avalon-MM data/instruction bus: converts one CPU-side request into one Avalon read or write transaction.
- Holds `read`/`write` and all bus signals stable while the responder asserts `waitrequest`.
- Captures responder read data (registered by the responder, valid one cycle after acceptance) and returns a single-cycle completion pulse to the CPU core.
- Sits between the CPU datapath and any Avalon responder, including the randomised-latency test memory.

---
 rtl/avalon_bus_master.sv | 171 +++++++++++++++++
 tb/tb_avalon_bus_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_master.sv
// rtl/avalon_bus_master.sv - Avalon-MM initiator: turns one CPU request into one bus read or write.
// Every output is a flop; the bus is parked at RESET_VECTOR whenever no transfer is in flight.
module avalon_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_readdata,
  output logic        cpu_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // With the timeout disabled the counter simply parks at all-ones.
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES != 0) ? CNT_W'(TIMEOUT_CYCLES) : {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic [31:0]      address_q, address_d;
  logic [3:0]       byteenable_q, byteenable_d;
  logic [31:0]      writedata_q, writedata_d;
  logic             cpu_busy_q, cpu_busy_d;
  logic             cpu_done_q, cpu_done_d;
  logic             cpu_error_q, cpu_error_d;
  logic [31:0]      cpu_readdata_q, cpu_readdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_sat;

  assign cnt_sat = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    read_d         = read_q;
    write_d        = write_q;
    address_d      = address_q;
    byteenable_d   = byteenable_q;
    writedata_d    = writedata_q;
    cpu_busy_d     = cpu_busy_q;
    cpu_done_d     = 1'b0;
    cpu_error_d    = 1'b0;
    cpu_readdata_d = cpu_readdata_q;
    cnt_d          = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_addr[1:0] == 2'b00) begin
            address_d    = cpu_addr;
            byteenable_d = cpu_byteenable;
            writedata_d  = cpu_writedata;
            read_d       = ~cpu_write;
            write_d      = cpu_write;
            cpu_busy_d   = 1'b1;
            cnt_d        = '0;
            state_d      = S_ISSUE;
          end else begin
            // Misaligned requests never reach the bus.
            cpu_done_d     = 1'b1;
            cpu_error_d    = 1'b1;
            cpu_readdata_d = '0;
            state_d        = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        if (!waitrequest) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          address_d    = RESET_VECTOR;
          byteenable_d = '0;
          writedata_d  = '0;
          if (write_q) begin
            cpu_busy_d = 1'b0;
            cpu_done_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d    = S_RDATA;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_sat == CNT_LIMIT)) begin
          read_d         = 1'b0;
          write_d        = 1'b0;
          address_d      = RESET_VECTOR;
          byteenable_d   = '0;
          writedata_d    = '0;
          cpu_busy_d     = 1'b0;
          cpu_done_d     = 1'b1;
          cpu_error_d    = 1'b1;
          cpu_readdata_d = '0;
          cnt_d          = cnt_sat;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_sat;
        end
      end

      S_RDATA: begin
        // Responder data is registered, so it is valid in the cycle after acceptance.
        cpu_readdata_d = readdata;
        cpu_busy_d     = 1'b0;
        cpu_done_d     = 1'b1;
        state_d        = S_DONE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      address_q      <= RESET_VECTOR;
      byteenable_q   <= '0;
      writedata_q    <= '0;
      cpu_busy_q     <= 1'b0;
      cpu_done_q     <= 1'b0;
      cpu_error_q    <= 1'b0;
      cpu_readdata_q <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      read_q         <= read_d;
      write_q        <= write_d;
      address_q      <= address_d;
      byteenable_q   <= byteenable_d;
      writedata_q    <= writedata_d;
      cpu_busy_q     <= cpu_busy_d;
      cpu_done_q     <= cpu_done_d;
      cpu_error_q    <= cpu_error_d;
      cpu_readdata_q <= cpu_readdata_d;
      cnt_q          <= cnt_d;
    end
  end

  assign read         = read_q;
  assign write        = write_q;
  assign address      = address_q;
  assign byteenable   = byteenable_q;
  assign writedata    = writedata_q;
  assign cpu_busy     = cpu_busy_q;
  assign cpu_done     = cpu_done_q;
  assign cpu_error    = cpu_error_q;
  assign cpu_readdata = cpu_readdata_q;

endmodule

// File: tb/tb_avalon_bus_master.sv
// tb/tb_avalon_bus_master.sv - scoreboard bench for avalon_bus_master against a variable-latency memory.
module tb_avalon_bus_master;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write;
  logic [31:0] cpu_addr, cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_busy, cpu_done, cpu_error;
  logic [31:0] cpu_readdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  avalon_bus_master #(.TIMEOUT_CYCLES(4), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_byteenable(cpu_byteenable), .cpu_writedata(cpu_writedata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_readdata(cpu_readdata),
    .cpu_error(cpu_error), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  typedef struct {
    logic        err;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, passes = 0;
  int          cyc = 0, done_cnt = 0, issued = 0;
  logic [31:0] mem[16];
  logic [31:0] shadow[16];
  bit          rnd_mode = 0, stuck = 0, rd_pending = 0;
  int          stall_target = 0, stall_cnt = 0;
  logic [31:0] rd_val;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Responder: decides waitrequest for the current cycle; read data appears one cycle after acceptance.
  initial begin
    waitrequest = 1'b0;
    readdata    = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        readdata   = rd_val;
        rd_pending = 0;
      end else begin
        readdata = 32'hA5A5A5A5;
      end
      if (read || write) begin
        if (stuck || stall_cnt < stall_target) begin
          waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          waitrequest = 1'b0;
          stall_cnt   = 0;
          if (write) mem[address[5:2]] = merge(mem[address[5:2]], writedata, byteenable);
          else begin
            rd_pending = 1;
            rd_val     = mem[address[5:2]];
          end
          if (rnd_mode) stall_target = $urandom_range(0, 2);
        end
      end else begin
        waitrequest = 1'b0;
        stall_cnt   = 0;
      end
    end
  end

  // Monitor: bus-protocol checks every cycle, scoreboard pop on every completion.
  initial begin
    logic        p_rd, p_wr, p_wreq;
    logic [31:0] p_addr, p_wd;
    logic [3:0]  p_be;
    exp_t        e;
    p_rd = 0; p_wr = 0; p_wreq = 0; p_addr = 0; p_wd = 0; p_be = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (read || write) check("rd_wr_exclusive", 72'(read & write), 72'(0));
        if ((p_rd || p_wr) && p_wreq && !cpu_done)
          check("bus_hold", {read, write, address, byteenable, writedata},
                {p_rd, p_wr, p_addr, p_be, p_wd});
        if (cpu_done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got cpu_done=1 expected 0 (nothing outstanding)");
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_err"}, 72'(cpu_error), 72'(e.err));
            if (e.chk_data) check({e.name, "_rdata"}, 72'(cpu_readdata), 72'(e.data));
            if (e.cyc >= 0) check({e.name, "_latency"}, 72'(cyc), 72'(e.cyc));
          end
        end
      end
      p_rd = read; p_wr = write; p_wreq = waitrequest;
      p_addr = address; p_be = byteenable; p_wd = writedata;
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int lat, input bit err, input bit chk,
                       input logic [31:0] exp_rd, input string name);
    exp_t e;
    cpu_req = 1; cpu_write = wr; cpu_addr = a; cpu_byteenable = be; cpu_writedata = wd;
    e.err = err; e.chk_data = chk; e.data = exp_rd; e.name = name;
    e.cyc = (lat < 0) ? -1 : cyc + lat;
    exp_q.push_back(e);
    issued++;
    if (wr && !err) shadow[a[5:2]] = merge(shadow[a[5:2]], wd, be);
  endtask

  task automatic wait_done(input string name, output int rd_cyc, output int wr_cyc,
                           output logic [31:0] f_addr, output logic [3:0] f_be,
                           output logic [31:0] f_wd);
    bit got;
    bit seen;
    got = 0; seen = 0; rd_cyc = 0; wr_cyc = 0; f_addr = 0; f_be = 0; f_wd = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      cpu_req = 0;
      if (read) rd_cyc++;
      if (write) wr_cyc++;
      if ((read || write) && !seen) begin
        seen = 1; f_addr = address; f_be = byteenable; f_wd = writedata;
      end
      if (cpu_done) got = 1;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s_done_wait: got cpu_done=0 for 40 cycles expected 1", name);
    end
    @(negedge clk);
  endtask

  initial begin
    int          rc, wc;
    logic [31:0] fa, fw;
    logic [3:0]  fb;
    bit          got, wr;
    int          idx;
    logic [3:0]  be;
    logic [31:0] wd;

    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h10000000 + i;
      shadow[i] = mem[i];
    end
    mem[8] = 32'h12345678;
    shadow[8] = 32'h12345678;
    reset = 1; cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_byteenable = 0; cpu_writedata = 0;
    repeat (3) @(negedge clk);
    check("rst_address", 72'(address), 72'(RV));
    check("rst_rw", 72'({read, write}), 72'(0));
    check("rst_be_wd", 72'({byteenable, writedata}), 72'(0));
    check("rst_busy_done_err", 72'({cpu_busy, cpu_done, cpu_error}), 72'(0));
    check("rst_readdata", 72'(cpu_readdata), 72'(0));
    reset = 0;
    @(negedge clk);

    issue(1, 32'hBFC00010, 4'hF, 32'hDEADBEEF, 2, 0, 0, 0, "wr_basic");
    wait_done("wr_basic", rc, wc, fa, fb, fw);
    check("wr_basic_write_cycles", 72'(wc), 72'(1));
    check("wr_basic_read_cycles", 72'(rc), 72'(0));
    check("wr_basic_bus", {fa, fb, fw}, {32'hBFC00010, 4'hF, 32'hDEADBEEF});

    stall_target = 3;
    issue(0, 32'hBFC00020, 4'hF, 32'h0, 6, 0, 1, 32'h12345678, "rd_wait3");
    wait_done("rd_wait3", rc, wc, fa, fb, fw);
    stall_target = 0;
    check("rd_wait3_read_cycles", 72'(rc), 72'(4));
    check("rd_wait3_address", 72'(fa), 72'(32'hBFC00020));
    check("rd_wait3_busy_after", 72'(cpu_busy), 72'(0));

    issue(0, 32'hBFC00002, 4'hF, 32'h0, 1, 1, 0, 0, "unaligned");
    wait_done("unaligned", rc, wc, fa, fb, fw);
    check("unaligned_bus_cycles", 72'(rc + wc), 72'(0));

    stuck = 1;
    issue(0, 32'hBFC00020, 4'hF, 32'h0, 5, 1, 1, 32'h0, "timeout");
    wait_done("timeout", rc, wc, fa, fb, fw);
    stuck = 0;
    check("timeout_read_cycles", 72'(rc), 72'(4));

    stall_target = 3;
    cpu_req = 1; cpu_write = 0; cpu_addr = 32'hBFC00024; cpu_byteenable = 4'hF;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    check("rst_mid_read_before", 72'(read), 72'(1));
    reset = 1;
    #1;
    check("rst_mid_rw", 72'({read, write}), 72'(0));
    check("rst_mid_address", 72'(address), 72'(RV));
    check("rst_mid_busy", 72'(cpu_busy), 72'(0));
    @(negedge clk);
    reset = 0;
    stall_target = 0;
    repeat (3) @(negedge clk);
    issue(0, 32'hBFC00010, 4'hF, 32'h0, 3, 0, 1, 32'hDEADBEEF, "post_rst_rd");
    wait_done("post_rst_rd", rc, wc, fa, fb, fw);

    rnd_mode = 1;
    stall_target = 1;
    for (int i = 0; i < 50; i++) begin
      wr  = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      be  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      issue(wr, 32'h00001000 + 32'(idx * 4), be, wd, -1, 0, !wr,
            wr ? 32'h0 : shadow[idx], $sformatf("b2b%0d", i));
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (cpu_done) got = 1;
      end
      if (!got) begin
        checks++;
        $display("FAIL b2b%0d_done_wait: got cpu_done=0 for 20 cycles expected 1", i);
        break;
      end
    end
    cpu_req = 0;
    rnd_mode = 0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 72'(exp_q.size()), 72'(0));
    check("done_count", 72'(done_cnt), 72'(issued));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
